// File: rtl/batcharger_adcseq.sv
// batcharger_adcseq
// Sequences a single shared 8-bit ADC across the battery charger's
// voltage, current and temperature monitor channels. Each channel's most
// recent result is kept in its own register. vtok_o reports when every
// enabled channel holds a fresh sample.
//
// Parameters:
//   SETTLE  - mux settling cycles between an adc_sel_o change and adc_start_o
//   TIMEOUT - CONVERT cycles allowed while waiting for adc_eoc_i
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   en_i         sequencer enable
//   vmonen_i     voltage channel enable
//   imonen_i     current channel enable
//   tmonen_i     temperature channel enable
//   adc_data_i   ADC result, valid while adc_eoc_i is high
//   adc_eoc_i    ADC end-of-conversion strobe
//   adc_sel_o    mux select: 0 = V, 1 = I, 2 = T
//   adc_start_o  one-cycle conversion request
//   vbat_o       last voltage result
//   ibat_o       last current result
//   tbat_o       last temperature result
//   vtok_o       all enabled channels are fresh
//   err_o        sticky conversion-timeout flag
module batcharger_adcseq #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       vmonen_i,
  input  logic       imonen_i,
  input  logic       tmonen_i,
  input  logic [7:0] adc_data_i,
  input  logic       adc_eoc_i,
  output logic [1:0] adc_sel_o,
  output logic       adc_start_o,
  output logic [7:0] vbat_o,
  output logic [7:0] ibat_o,
  output logic [7:0] tbat_o,
  output logic       vtok_o,
  output logic       err_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_START   = 2'd2,
    ST_CONVERT = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic        start_q, start_d;
  logic [7:0]  vbat_q, vbat_d, ibat_q, ibat_d, tbat_q, tbat_d;
  logic [2:0]  fresh_q, fresh_d;
  logic [2:0]  mon_q;
  logic        vtok_q, vtok_d;
  logic        err_q, err_d;

  logic [2:0]  mon_s;
  logic [2:0]  mask_s;
  logic [2:0]  rise_s;
  logic [2:0]  nxt_s;
  logic        adv_s;

  // Round-robin search starting after cur; cur itself is tried last.
  // Returns {found, channel}.
  function automatic logic [2:0] next_ch(input logic [1:0] cur, input logic [2:0] m);
    logic [3:0] m4;
    logic [1:0] c1, c2;
    m4 = {1'b0, m};
    case (cur)
      2'd0:    begin c1 = 2'd1; c2 = 2'd2; end
      2'd1:    begin c1 = 2'd2; c2 = 2'd0; end
      default: begin c1 = 2'd0; c2 = 2'd1; end
    endcase
    if (m4[c1]) begin
      next_ch = {1'b1, c1};
    end else if (m4[c2]) begin
      next_ch = {1'b1, c2};
    end else if (m4[cur]) begin
      next_ch = {1'b1, cur};
    end else begin
      next_ch = {1'b0, cur};
    end
  endfunction

  assign mon_s  = {tmonen_i, imonen_i, vmonen_i};
  assign mask_s = mon_s & {3{en_i}};
  assign rise_s = mon_s & ~mon_q;
  assign nxt_s  = next_ch(sel_q, mask_s);

  // Next-state, capture and status logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    vbat_d  = vbat_q;
    ibat_d  = ibat_q;
    tbat_d  = tbat_q;
    err_d   = err_q;
    adv_s   = 1'b0;
    // A channel that has just been switched on must be re-sampled.
    fresh_d = fresh_q & ~rise_s;

    if (!en_i) begin
      // Leave adc_sel as is; a late strobe lands in IDLE and is ignored.
      state_d = ST_IDLE;
      fresh_d = 3'b000;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mask_s != 3'b000) begin
            if (mask_s[0]) begin
              sel_d = 2'd0;
            end else if (mask_s[1]) begin
              sel_d = 2'd1;
            end else begin
              sel_d = 2'd2;
            end
            cnt_d   = 8'd0;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_START;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_START: begin
          cnt_d   = 8'd0;
          state_d = ST_CONVERT;
        end
        ST_CONVERT: begin
          // A strobe in the final allowed cycle beats the timeout.
          if (adc_eoc_i) begin
            adv_s = 1'b1;
            case (sel_q)
              2'd0:    begin vbat_d = adc_data_i; fresh_d[0] = 1'b1; end
              2'd1:    begin ibat_d = adc_data_i; fresh_d[1] = 1'b1; end
              2'd2:    begin tbat_d = adc_data_i; fresh_d[2] = 1'b1; end
              default: begin vbat_d = vbat_q; end
            endcase
          end else if (cnt_q == TIMEOUT_LAST) begin
            adv_s = 1'b1;
            err_d = 1'b1;
            case (sel_q)
              2'd0:    fresh_d[0] = 1'b0;
              2'd1:    fresh_d[1] = 1'b0;
              2'd2:    fresh_d[2] = 1'b0;
              default: fresh_d = fresh_d;
            endcase
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (adv_s) begin
        if (nxt_s[2]) begin
          sel_d   = nxt_s[1:0];
          cnt_d   = 8'd0;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        adv_s = 1'b0;
      end
    end

    start_d = (state_d == ST_START) ? 1'b1 : 1'b0;
    // Uses registered fresh bits, so vtok rises one edge after capture.
    vtok_d  = (mask_s != 3'b000) && ((fresh_q & ~rise_s & mask_s) == mask_s) && !err_q;
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 2'd0;
      start_q <= 1'b0;
      vbat_q  <= 8'd0;
      ibat_q  <= 8'd0;
      tbat_q  <= 8'd0;
      fresh_q <= 3'b000;
      mon_q   <= 3'b000;
      vtok_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      vbat_q  <= vbat_d;
      ibat_q  <= ibat_d;
      tbat_q  <= tbat_d;
      fresh_q <= fresh_d;
      mon_q   <= mon_s;
      vtok_q  <= vtok_d;
      err_q   <= err_d;
    end
  end

  assign adc_sel_o   = sel_q;
  assign adc_start_o = start_q;
  assign vbat_o      = vbat_q;
  assign ibat_o      = ibat_q;
  assign tbat_o      = tbat_q;
  assign vtok_o      = vtok_q;
  assign err_o       = err_q;

endmodule

// File: doc/batcharger_adcseq.md
# batcharger_adcseq

Monitor-side ADC sequencer for the battery charger. It takes the per-channel monitor enables (`imonen`, `vmonen`, `tmonen`) issued by the charger controller and drives a single shared 8-bit ADC through its analog mux. It stores one conversion result per channel and returns `vbat`, `ibat` and `tbat` to the controller. `vtok` tells the controller when every enabled channel holds a fresh sample.

## Interface
- `SETTLE`, default 4: mux settling cycles between a change of `adc_sel` and `adc_start`. Legal range 1–255.
- `TIMEOUT`, default 64: maximum CONVERT cycles allowed while waiting for `adc_eoc`. Legal range 1–255.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  sequencer enable.
- `vmonen`, `imonen`, `tmonen`  in  1 each  channel enables for voltage, current and temperature.
- `adc_data`  in  8  ADC result; valid in the cycle `adc_eoc` is high.
- `adc_eoc`  in  1  end-of-conversion strobe from the ADC.
- `adc_sel`  out  2  mux select: 0 = V, 1 = I, 2 = T; 3 is never driven.
- `adc_start`  out  1  one-cycle conversion request.
- `vbat`, `ibat`, `tbat`  out  8 each  last captured result per channel.
- `vtok`  out  1  all enabled channels are fresh.
- `err`  out  1  sticky conversion-timeout flag.

## Operation
- Reset values:
  - `vbat`/`ibat`/`tbat` = 0, `vtok` = 0, `err` = 0, `adc_start` = 0, `adc_sel` = 0.
  - State = IDLE, fresh bits = 000, counter = 0.
- The enable mask is {`tmonen`, `imonen`, `vmonen`} ANDed with `en`.
- States:
  - IDLE: if the mask is non-zero, pick the first enabled channel in the order V, I, T. Load `adc_sel`, clear the counter and go to SETTLE.
  - SETTLE: count to SETTLE−1, then go to START.
  - START: `adc_start` = 1 for this single cycle. Go to CONVERT with the counter cleared.
  - CONVERT: wait for `adc_eoc`.
    - On `adc_eoc` = 1: capture `adc_data` into the register selected by `adc_sel` and set that channel's fresh bit.
    - If TIMEOUT CONVERT cycles pass with no `adc_eoc`: set `err`, clear that channel's fresh bit and leave its data unchanged.
    - In either case, select the next channel.
- Next channel: search round-robin from current channel +1 (V→I→T→V) for the first set mask bit. The current channel is checked last.
  - If a channel is found, load `adc_sel`, clear the counter and go to SETTLE.
  - If no channel is found, go to IDLE.
  - If the same channel is found again, SETTLE is still executed.
- Fresh bits:
  - Each bit is cleared on the rising edge of its own enable.
  - All bits are cleared when `en` = 0.
- `vtok` is registered: `vtok` <= (mask ≠ 0) AND ((fresh AND mask) == mask) AND NOT `err`.
- `err` is sticky. It is cleared only by `rst` or by `en` = 0.
- Disabled channels keep their last captured value.

## Timing
- `adc_sel` changes on the edge entering SETTLE and is stable through START and CONVERT.
- `adc_start` rises exactly SETTLE cycles after `adc_sel` changes.
- `adc_eoc` is sampled only in CONVERT, starting the cycle after `adc_start`. An `adc_eoc` in any other state is ignored.
- If `adc_eoc` arrives in the TIMEOUT-th CONVERT cycle, the capture wins and there is no timeout.
- Data capture:
  - The result register updates on the edge that samples `adc_eoc`.
  - `vtok` can rise one edge later.
- Channel disabled during CONVERT: the conversion completes and the value is stored. The next-channel search then skips the disabled channel.
- `en` falling in any state:
  - Go to IDLE on the next edge and set `adc_start` = 0.
  - Clear the fresh bits, `vtok` and `err`.
  - `adc_sel` holds its value and a late `adc_eoc` is ignored.
- `rst` mid-operation: all outputs take their reset values immediately (asynchronously).
- Latency from IDLE with only `vmonen` set and an ADC delay of D cycles:
  - START at cycle SETTLE+1.
  - Capture at cycle SETTLE+1+D.
  - `vtok` high at cycle SETTLE+2+D.

## Test plan
- Reset release with `en`=1 and only `vmonen`, SETTLE=4, ADC answers 3 cycles after start with 0xB4:
  - `adc_sel`=0, `adc_start` pulses once.
  - `vbat`=0xB4, `vtok`=1 one cycle after capture.
  - `ibat`/`tbat` stay 0.
- All three enabled, ADC returns 0x10/0x20/0x30 in scan order:
  - `adc_sel` sequence is 0,1,2,0.
  - `vtok` stays 0 until `tbat`=0x30 is captured, then 1.
- TIMEOUT=8, `adc_eoc` never asserted on the I channel:
  - After 8 CONVERT cycles, `err`=1 and `vtok`=0.
  - `ibat` unchanged, scan moves to T.
  - `en` pulsed low clears `err`.
- `adc_eoc` in the same cycle as `adc_start`, then a real `adc_eoc` 2 cycles later with 0x55: the first strobe is ignored and 0x55 is captured.
- With `vtok`=1 on V+T, `imonen` rises:
  - `vtok` drops to 0 on the next edge.
  - `vtok` returns to 1 only after `ibat` is captured.
- `en` dropped mid-CONVERT, then a late `adc_eoc` with 0xFF:
  - State goes to IDLE, no capture occurs.
  - `vtok`=0 and the held register values are unchanged.
